// File: rtl/fifo_prog.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds and sticky error flags.
// Define FIFO_PROG_FWFT_EN for first-word-fall-through output; default is registered-read output.
`timescale 1ns / 1ps
module fifo_prog #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  pop_valid,
  input  logic [ADDR_WIDTH:0]   af_level,
  input  logic [ADDR_WIDTH:0]   ae_level,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DepthW = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [DATA_WIDTH-1:0] mem [Depth];

  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  af_q, af_d;
  logic                  ae_q, ae_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic push_acc;
  logic pop_acc;
  logic ram_rd;
`ifdef FIFO_PROG_FWFT_EN
  logic [ADDR_WIDTH:0] ram_cnt;
`endif

  always_comb begin
    push_acc = push & ~full_q;
    pop_acc  = pop & ~empty_q;
    count_d  = count_q + (ADDR_WIDTH + 1)'(push_acc) - (ADDR_WIDTH + 1)'(pop_acc);

`ifdef FIFO_PROG_FWFT_EN
    // Words still in the RAM, excluding the one presented on pop_data.
    ram_cnt  = wr_ptr_q - rd_ptr_q;
    ram_rd   = (ram_cnt != '0) & (~valid_q | pop_acc);
    valid_d  = ram_rd | (valid_q & ~pop_acc);
`else
    ram_rd   = pop_acc;
    valid_d  = pop_acc;
`endif

    wr_ptr_d = wr_ptr_q + (ADDR_WIDTH + 1)'(push_acc);
    rd_ptr_d = rd_ptr_q + (ADDR_WIDTH + 1)'(ram_rd);
    data_d   = ram_rd ? mem[rd_ptr_q[ADDR_WIDTH-1:0]] : data_q;

`ifdef FIFO_PROG_FWFT_EN
    full_d   = (count_d == DepthW);
    empty_d  = ~valid_d;
`else
    // Equal addresses with differing wrap bits mean full; identical pointers mean empty.
    full_d   = (wr_ptr_d == (rd_ptr_d ^ DepthW));
    empty_d  = (wr_ptr_d == rd_ptr_d);
`endif

    af_d     = (count_d >= af_level);
    ae_d     = (count_d <= ae_level);
    ovf_d    = ovf_q | (push & full_q);
    udf_d    = udf_q | (pop & empty_q);

    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      full_d   = 1'b0;
      empty_d  = 1'b1;
      af_d     = 1'b0;
      ae_d     = 1'b1;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
      valid_d  = 1'b0;
      data_d   = data_q;
    end
  end

  // Data array carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (push_acc && !clear) begin
      mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
    end
  end

  assign pop_data     = data_q;
  assign pop_valid    = valid_q;
  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  a_count_range: assert property (@(posedge clk) disable iff (!rst_n) count_q <= DepthW);
  a_full_empty:  assert property (@(posedge clk) disable iff (!rst_n) !(full_q && empty_q));

endmodule

// File: tb/tb_fifo_prog.sv
// Scoreboard bench for fifo_prog (registered-read build, DEPTH=4, 8-bit data).
`timescale 1ns / 100ps
module tb_fifo_prog;

  localparam int Depth = 4;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       push;
  logic [7:0] push_data;
  logic       pop;
  logic [7:0] pop_data;
  logic       pop_valid;
  logic [2:0] af_level;
  logic [2:0] ae_level;
  logic [2:0] count;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;

  fifo_prog #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .push        (push),
    .push_data   (push_data),
    .pop         (pop),
    .pop_data    (pop_data),
    .pop_valid   (pop_valid),
    .af_level    (af_level),
    .ae_level    (ae_level),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Model: stored contents, expected-output queue, sticky flags and last read word.
  logic [7:0] sb [$];
  logic [7:0] exp_q [$];
  int         m_count = 0;
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;
  logic       m_popped = 1'b0;
  logic [7:0] m_last = 8'h00;

  logic [17:0] status;
  assign status = {count, full, empty, almost_full, almost_empty, overflow, underflow,
                   pop_valid, pop_data};

  function automatic logic [17:0] model_status();
    return {3'(m_count), m_count == Depth, m_count == 0, m_count >= int'(af_level),
            m_count <= int'(ae_level), m_ovf, m_udf, m_popped, m_last};
  endfunction

  task automatic model_reset();
    sb.delete();
    exp_q.delete();
    m_count  = 0;
    m_ovf    = 1'b0;
    m_udf    = 1'b0;
    m_popped = 1'b0;
    m_last   = 8'h00;
  endtask

  // One clock of stimulus; updates the model, returns at edge+1.
  task automatic step(input bit p, input logic [7:0] d, input bit q, input bit c);
    bit ap, aq;
    push = p; push_data = d; pop = q; clear = c;
    ap = p && (m_count < Depth);
    aq = q && (m_count > 0);
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; clear = 1'b0;
    m_popped = 1'b0;
    if (c) begin
      sb.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (p && !ap) m_ovf = 1'b1;
      if (q && !aq) m_udf = 1'b1;
      if (aq) begin
        m_last   = sb.pop_front();
        m_popped = 1'b1;
        exp_q.push_back(m_last);
      end
      if (ap) sb.push_back(d);
    end
    m_count = sb.size();
  endtask

  task automatic test_reset();
    logic [7:0] e;
    rst_n = 1'b0;
    #12;
    n_vec++;
    if (status !== 18'b000_0101000_0000_0000) begin
      n_bad++;
      $display("FAIL reset_state: got %h want %h", status, 18'b000_0101000_0000_0000);
    end
    rst_n = 1'b1;
    step(0, 8'h00, 0, 0);
    n_vec++;
    if (status !== model_status()) begin
      n_bad++;
      $display("FAIL reset_idle: got %h want %h", status, model_status());
    end
    e = 8'h00;
  endtask

  task automatic test_fill();
    logic [7:0] fd [4];
    fd = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      step(1, fd[i], 0, 0);
      n_vec++;
      if (status !== model_status()) begin
        n_bad++;
        $display("FAIL fill_%0d: got %h want %h", i, status, model_status());
      end
    end
    n_vec++;
    if (full !== 1'b1 || almost_full !== 1'b1 || count !== 3'd4) begin
      n_bad++;
      $display("FAIL fill_full: got full=%b af=%b cnt=%0d want 1 1 4", full, almost_full, count);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] e;
    step(1, 8'h55, 1, 0);
    n_vec++;
    if (status !== model_status()) begin
      n_bad++;
      $display("FAIL ovf_status: got %h want %h", status, model_status());
    end
    if (pop_valid === 1'b1) begin
      e = exp_q.pop_front();
      n_vec++;
      if (pop_data !== e || e !== 8'h11) begin
        n_bad++;
        $display("FAIL ovf_data: got %h want %h", pop_data, e);
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 8'h00, 1, 0);
      n_vec++;
      if (status !== model_status()) begin
        n_bad++;
        $display("FAIL drain_%0d: got %h want %h", i, status, model_status());
      end
      if (pop_valid === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (pop_data !== e) begin
          n_bad++;
          $display("FAIL drain_data_%0d: got %h want %h", i, pop_data, e);
        end
      end
    end
    step(0, 8'h00, 0, 0);
    n_vec++;
    if (status !== model_status()) begin
      n_bad++;
      $display("FAIL hold_after_drain: got %h want %h", status, model_status());
    end
  endtask

  task automatic test_underflow();
    logic [7:0] e;
    step(1, 8'hA5, 1, 0);
    n_vec++;
    if (status !== model_status()) begin
      n_bad++;
      $display("FAIL udf_status: got %h want %h", status, model_status());
    end
    step(0, 8'h00, 1, 0);
    n_vec++;
    if (status !== model_status()) begin
      n_bad++;
      $display("FAIL udf_pop_status: got %h want %h", status, model_status());
    end
    if (pop_valid === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (pop_data !== e || e !== 8'hA5) begin
        n_bad++;
        $display("FAIL udf_data: got %h want %h", pop_data, e);
      end
    end
  endtask

  task automatic test_clear();
    step(1, 8'h61, 0, 0);
    step(1, 8'h62, 0, 0);
    step(1, 8'h99, 1, 1);
    n_vec++;
    if (status !== model_status()) begin
      n_bad++;
      $display("FAIL clear_status: got %h want %h", status, model_status());
    end
    step(1, 8'h63, 0, 0);
    n_vec++;
    if (status !== model_status()) begin
      n_bad++;
      $display("FAIL clear_then_push: got %h want %h", status, model_status());
    end
    step(0, 8'h00, 0, 1);
  endtask

  task automatic test_thresholds();
    step(1, 8'h71, 0, 0);
    step(1, 8'h72, 0, 0);
    ae_level = 3'd2;
    af_level = 3'd2;
    step(0, 8'h00, 0, 0);
    n_vec++;
    if (status !== model_status() || almost_full !== 1'b1 || almost_empty !== 1'b1) begin
      n_bad++;
      $display("FAIL thr_change: got %h want %h", status, model_status());
    end
    af_level = 3'd5;
    step(1, 8'h73, 0, 0);
    step(1, 8'h74, 0, 0);
    n_vec++;
    if (status !== model_status() || almost_full !== 1'b0) begin
      n_bad++;
      $display("FAIL thr_af_above_depth: got %h want %h", status, model_status());
    end
    af_level = 3'd3;
    ae_level = 3'd1;
    step(0, 8'h00, 0, 1);
    n_vec++;
    if (status !== model_status()) begin
      n_bad++;
      $display("FAIL thr_clear: got %h want %h", status, model_status());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    for (int i = 0; i < 3; i++) step(1, 8'h10 + 8'(i), 0, 0);
    for (int i = 0; i < 11; i++) begin
      if (i < 8) step(1, 8'h20 + 8'(i), 1, 0);
      else step(0, 8'h00, 1, 0);
      n_vec++;
      if (status !== model_status()) begin
        n_bad++;
        $display("FAIL b2b_status_%0d: got %h want %h", i, status, model_status());
      end
      if (pop_valid === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (pop_data !== e) begin
          n_bad++;
          $display("FAIL b2b_data_%0d: got %h want %h", i, pop_data, e);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] e;
    step(1, 8'h81, 0, 0);
    step(1, 8'h82, 0, 0);
    #3;
    rst_n = 1'b0;
    #0.5;
    model_reset();
    n_vec++;
    if (status !== model_status()) begin
      n_bad++;
      $display("FAIL async_reset: got %h want %h", status, model_status());
    end
    #0.5;
    rst_n = 1'b1;
    step(1, 8'h77, 0, 0);
    n_vec++;
    if (status !== model_status() || count !== 3'd1) begin
      n_bad++;
      $display("FAIL first_push_after_reset: got %h want %h", status, model_status());
    end
    step(0, 8'h00, 1, 0);
    if (pop_valid === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (pop_data !== e || e !== 8'h77) begin
        n_bad++;
        $display("FAIL reset_pop_data: got %h want %h", pop_data, e);
      end
    end
    step(0, 8'h00, 0, 1);
    n_vec++;
    if (status !== model_status()) begin
      n_bad++;
      $display("FAIL clear_noop: got %h want %h", status, model_status());
    end
  endtask

  initial begin
    clear = 1'b0; push = 1'b0; pop = 1'b0; push_data = 8'h00;
    af_level = 3'd3;
    ae_level = 3'd1;
    test_reset();
    test_fill();
    test_overflow();
    test_underflow();
    test_clear();
    test_thresholds();
    test_back_to_back();
    test_async_reset();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL missing_reads: got %0d unread want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
